rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-source round-robin arbiter with a registered output slot. It sits directly upstream of the 8:1 16-bit selection stage (`sel_i` / `data_0_i..data_7_i` / `q_o`) and decides which of eight producers is forwarded. It also presents the winning index as a 3-bit select. Fairness is rotating priority, and a valid/ready handshake on the output gives single-entry buffering with backpressure.

## Interface
- `WIDTH`, default 16: data width of every source and of `data_o`.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in 8: per-source request; bit k means `data_k_i` is offered this cycle.
- `data_0_i` … `data_7_i` in WIDTH each: source payloads, sampled only on the granting edge.
- `gnt_o` out 8: combinational one-hot grant; source k is consumed in any cycle where `gnt_o[k]`=1.
- `ready_i` in 1: downstream accepts `data_o` this cycle.
- `valid_o` out 1: `data_o` / `sel_o` hold a pending item.
- `data_o` out WIDTH: registered payload of the last winner.
- `sel_o` out 3: registered index of the last winner.
- `count_o` out 16: number of items handed downstream (`valid_o & ready_i`), wraps modulo 2^16.

## Operation
- Internal state:
  - `ptr` (3 b): highest-priority index.
  - Output slot: `valid_o`, `data_o`, `sel_o`.
  - `count_o`.
- Search order is `ptr`, `ptr`+1, …, `ptr`+7, modulo 8. The winner k is the first index in that order with `req_i[k]`=1.
- `slot_free = ~valid_o | ready_i`.
- `accept = slot_free & |req_i`.
- `gnt_o = accept ? onehot(k) : 8'h00`. It is never more than one bit, and it is never asserted while `rst_i`=1.
- On an edge with `accept`:
  - `data_o <= data_k_i`, `sel_o <= k`, `valid_o <= 1`.
  - `ptr <= (k+1) mod 8` (3-bit wrap, 7 → 0).
- On an edge with `valid_o & ready_i & ~|req_i`: `valid_o <= 0`. `data_o` and `sel_o` retain their old values.
- On an edge with `valid_o & ~ready_i`: all state holds and `gnt_o` = 0. Requests are not lost; sources keep `req_i` asserted until granted.
- `count_o <= count_o + 1` on every edge with `valid_o & ready_i`, independent of `accept`. The increment wraps from 16'hFFFF to 16'h0000.
- `ptr` changes only on `accept`. Idle cycles do not rotate priority.
- Two states, defined by `valid_o`:
  - EMPTY → FULL on `accept`.
  - FULL → FULL on `accept` (simultaneous drain and refill) or on stall.
  - FULL → EMPTY on drain with no request.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `sel_o`=0, `count_o`=0, `ptr`=0, `gnt_o`=0.
- Reset takes effect immediately, independent of `clk_i`. Assertion mid-operation discards any held item and the item is not counted.
- `gnt_o` is combinational from `req_i`, `ptr`, `valid_o`, `ready_i`, and valid in the same cycle as the request.
- Latency from request to `valid_o` is 1 edge.
- With `ready_i` held high, throughput is one item per cycle, with no bubble between back-to-back items.
- A simultaneous drain and grant in one cycle replaces the slot contents on the same edge. `valid_o` stays 1.
- Upstream contract: `data_k_i` must be stable in any cycle where `req_i[k]`=1.

## Test plan
- Reset:
  - Stimulus: assert `rst_i` asynchronously with `req_i`=8'hFF.
  - Required: `valid_o`=0, `data_o`=0, `sel_o`=0, `count_o`=0, `gnt_o`=8'h00 immediately.
  - After release, the first grant goes to index 0.
- Single request:
  - Stimulus: `req_i`=8'h04, `data_2_i`=16'hBEEF, `ready_i`=1.
  - Same cycle: `gnt_o`=8'h04.
  - Next edge: `valid_o`=1, `data_o`=16'hBEEF, `sel_o`=2.
  - Following edge: `count_o`=1.
- Full rotation:
  - Stimulus: `req_i`=8'hFF, `ready_i`=1 for 10 cycles, each `data_k_i`=16'h1000+k.
  - Required: `sel_o` sequence 0,1,2,3,4,5,6,7,0,1 with matching `data_o`.
  - `count_o` reaches 9 at the tenth output edge.
- Backpressure:
  - Stimulus: `valid_o`=1 with `sel_o`=3, `ready_i`=0 for 5 cycles, `req_i`=8'hFF.
  - Required: `gnt_o`=0 and `data_o`/`sel_o`/`count_o` stable.
  - Then raise `ready_i`. Same cycle: `gnt_o`=8'h10. Next edge: `sel_o`=4 and `count_o` +1.
- Wrap-around and skip:
  - Stimulus: with `ptr`=6 (after a grant to 5), apply `req_i`=8'h21.
  - Required: grant to 0 (search 6,7,0), then `ptr`=1, then grant to 5.
- Counter wrap:
  - Stimulus: preload by running 65535 transfers, then perform one more.
  - Required: `count_o`=16'h0000, `valid_o` behaviour unaffected.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-source round-robin arbiter with a single registered output slot.
// Rotating priority, valid/ready backpressure, and a count of delivered items.
module rr_arbiter8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       req_i,
    input  logic [WIDTH-1:0] data_0_i,
    input  logic [WIDTH-1:0] data_1_i,
    input  logic [WIDTH-1:0] data_2_i,
    input  logic [WIDTH-1:0] data_3_i,
    input  logic [WIDTH-1:0] data_4_i,
    input  logic [WIDTH-1:0] data_5_i,
    input  logic [WIDTH-1:0] data_6_i,
    input  logic [WIDTH-1:0] data_7_i,
    output logic [7:0]       gnt_o,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [2:0]       sel_o,
    output logic [15:0]      count_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic [15:0]      count_q, count_d;

    logic [WIDTH-1:0] src [8];
    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             slot_free;
    logic             accept;
    logic             drain;

    assign src[0] = data_0_i;
    assign src[1] = data_1_i;
    assign src[2] = data_2_i;
    assign src[3] = data_3_i;
    assign src[4] = data_4_i;
    assign src[5] = data_5_i;
    assign src[6] = data_6_i;
    assign src[7] = data_7_i;

    // First requester found scanning ptr, ptr+1, ... with 3-bit wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign slot_free = (state_q == EMPTY) | ready_i;
    assign accept    = slot_free & win_found & ~rst_i;
    assign drain     = (state_q == FULL) & ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (ready_i && !win_found) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q == FULL);
        gnt_o   = accept ? (8'(1) << win_idx) : '0;
        data_o  = data_q;
        sel_o   = sel_q;
        count_o = count_q;
    end

    // Slot payload and priority move only on a grant; the counter only on a handoff.
    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        count_d = count_q;
        if (accept) begin
            ptr_d  = win_idx + 3'd1;
            data_d = src[win_idx];
            sel_d  = win_idx;
        end
        if (drain) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected items are queued at grant time and
// checked by an independent monitor at each valid/ready handoff.
module tb_rr_arbiter8;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [15:0] d [8];
    logic [7:0]  gnt;
    logic        ready;
    logic        valid;
    logic [15:0] dout;
    logic [2:0]  sel;
    logic [15:0] count;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [18:0] sb [$];

    rr_arbiter8 #(.WIDTH(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .data_0_i (d[0]),
        .data_1_i (d[1]),
        .data_2_i (d[2]),
        .data_3_i (d[3]),
        .data_4_i (d[4]),
        .data_5_i (d[5]),
        .data_6_i (d[6]),
        .data_7_i (d[7]),
        .gnt_o    (gnt),
        .ready_i  (ready),
        .valid_o  (valid),
        .data_o   (dout),
        .sel_o    (sel),
        .count_o  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Check the combinational grant for this cycle and queue the item it implies.
    task automatic expect_grant(input int k);
        #1;
        check("gnt", {24'd0, gnt}, {24'd0, 8'(1) << k});
        sb.push_back({3'(k), d[k]});
    endtask

    // Monitor: every handoff must match the oldest queued item.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {13'd0, sel, dout}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                check("sb_sel", {29'd0, sel}, {29'd0, e[18:16]});
                check("sb_data", {16'd0, dout}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 8; k++) d[k] = 16'h1000 + 16'(k);

        // Reset asserted before any clock edge with all sources requesting.
        rst   = 1'b1;
        req   = 8'hFF;
        ready = 1'b1;
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {16'd0, dout}, 32'd0);
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_count", {16'd0, count}, 32'd0);
        check("rst_gnt", {24'd0, gnt}, 32'd0);
        @(posedge clk);
        tick;
        rst = 1'b0;

        // First grant after reset goes to index 0 (ptr -> 1).
        expect_grant(0);
        tick;
        // Single request on source 2 while item 0 drains.
        req  = 8'h04;
        d[2] = 16'hBEEF;
        expect_grant(2);
        tick;
        check("single_valid", {31'd0, valid}, 32'd1);
        check("single_sel", {29'd0, sel}, 32'd2);
        check("single_data", {16'd0, dout}, 32'h0000_BEEF);
        check("single_count", {16'd0, count}, 32'd1);
        req = 8'h00;
        #1;
        check("idle_gnt", {24'd0, gnt}, 32'd0);
        tick;
        check("idle_valid", {31'd0, valid}, 32'd0);
        check("idle_count", {16'd0, count}, 32'd2);

        // Load source 3 with ready low, then reset mid-operation: item is dropped.
        d[2]  = 16'h1002;
        req   = 8'h08;
        ready = 1'b0;
        expect_grant(3);
        tick;
        check("held_valid", {31'd0, valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_sel", {29'd0, sel}, 32'd0);
        check("mid_rst_data", {16'd0, dout}, 32'd0);
        check("mid_rst_count", {16'd0, count}, 32'd0);
        check("mid_rst_gnt", {24'd0, gnt}, 32'd0);
        tick;
        rst = 1'b0;

        // Full rotation from ptr=0: 0..7,0,1; nine handoffs by the tenth output edge.
        req   = 8'hFF;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_grant(i % 8);
            tick;
            check("rot_sel", {29'd0, sel}, 32'(i % 8));
        end
        check("rot_count", {16'd0, count}, 32'd9);

        // Advance to sel=3 held in the slot (count 11, ptr 4).
        expect_grant(2);
        tick;
        expect_grant(3);
        tick;
        check("pre_bp_count", {16'd0, count}, 32'd11);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_gnt", {24'd0, gnt}, 32'd0);
            tick;
            check("bp_sel", {29'd0, sel}, 32'd3);
            check("bp_data", {16'd0, dout}, 32'h0000_1003);
            check("bp_count", {16'd0, count}, 32'd11);
            check("bp_valid", {31'd0, valid}, 32'd1);
        end
        ready = 1'b1;
        expect_grant(4);
        tick;
        check("bp_release_sel", {29'd0, sel}, 32'd4);
        check("bp_release_count", {16'd0, count}, 32'd12);

        // Wrap and skip: grant 5 (ptr 6), then req 0x21 searches 6,7,0 -> 0, then 5.
        req = 8'h20;
        expect_grant(5);
        tick;
        req = 8'h21;
        expect_grant(0);
        tick;
        check("wrap_sel0", {29'd0, sel}, 32'd0);
        expect_grant(5);
        tick;
        check("wrap_sel5", {29'd0, sel}, 32'd5);
        req = 8'h00;
        tick;
        check("drain_valid", {31'd0, valid}, 32'd0);
        check("drain_sel_kept", {29'd0, sel}, 32'd5);
        check("drain_data_kept", {16'd0, dout}, 32'h0000_1005);
        check("drain_count", {16'd0, count}, 32'd16);

        // Counter wrap: 65520 back-to-back cycles take count from 16 to 16'hFFFF.
        req = 8'h01;
        for (int i = 0; i < 65520; i++) begin
            #1;
            sb.push_back({3'd0, d[0]});
            tick;
        end
        check("pre_wrap_count", {16'd0, count}, 32'h0000_FFFF);
        check("pre_wrap_valid", {31'd0, valid}, 32'd1);
        expect_grant(0);
        tick;
        check("wrap_count", {16'd0, count}, 32'd0);
        check("wrap_valid", {31'd0, valid}, 32'd1);
        req = 8'h00;
        tick;
        check("post_wrap_count", {16'd0, count}, 32'd1);
        check("post_wrap_valid", {31'd0, valid}, 32'd0);
        tick;
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
